// File: rtl/approx_err_accum.sv
// Error-statistics accumulator for approximate-multiplier evaluation: per-sample
// absolute error, plus run totals (sum, max, mismatch count) over N_SAMPLES pairs.
module approx_err_accum #(
  parameter int N_SAMPLES = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         p_approx,
  input  logic [63:0]         p_exact,
  output logic                busy,
  output logic                done,
  output logic [63+CNT_W:0]   err_sum,
  output logic [63:0]         err_max,
  output logic [CNT_W-1:0]    mis_cnt,
  output logic [CNT_W-1:0]    smp_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES);

  state_t state;
  state_t state_nxt;

  logic        accept;
  logic        clear;
  logic [64:0] diff;
  logic [64:0] diff_neg;
  logic [63:0] abs_diff;

  logic        s1_valid;
  logic        s1_neq;
  logic [63:0] s1_abs;
  logic        s2_valid;
  logic        s2_neq;
  logic [63:0] s2_abs;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The run ends on the count alone; DRAIN waits for both stages to empty so
  // the totals are final when DONE is entered.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (smp_cnt == LAST) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready drops as soon as the last sample is counted, so no extra pair can
  // slip in during the final RUN cycle.
  always_comb begin
    in_ready = (state == RUN) && (smp_cnt != LAST);
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
  end

  assign accept = in_valid && in_ready;
  assign clear  = start && ((state == IDLE) || (state == DONE));

  // 65-bit difference of sign-extended operands; its magnitude always fits 64 bits.
  assign diff     = {p_approx[63], p_approx} - {p_exact[63], p_exact};
  assign diff_neg = ~diff + 65'd1;
  assign abs_diff = diff[64] ? diff_neg[63:0] : diff[63:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_neq   <= 1'b0;
      s1_abs   <= '0;
      s2_valid <= 1'b0;
      s2_neq   <= 1'b0;
      s2_abs   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_abs <= abs_diff;
        s1_neq <= |diff;
      end
      s2_valid <= s1_valid;
      s2_abs   <= s1_abs;
      s2_neq   <= s1_neq;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      err_sum <= '0;
      err_max <= '0;
      mis_cnt <= '0;
      smp_cnt <= '0;
    end else begin
      if (accept) smp_cnt <= smp_cnt + 1'b1;
      if (s2_valid) begin
        err_sum <= err_sum + {{CNT_W{1'b0}}, s2_abs};
        if (s2_abs > err_max) err_max <= s2_abs;
        mis_cnt <= mis_cnt + CNT_W'(s2_neq);
      end
    end
  end

endmodule

// File: tb/tb_approx_err_accum.sv
// Self-checking bench for approx_err_accum: three instances (N=4, N=1, N=1024)
// share the stimulus; each scenario task targets one instance.
module tb_approx_err_accum;

  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [63:0] p_approx;
  logic [63:0] p_exact;

  logic        rdy  [3];
  logic        busy [3];
  logic        done [3];
  logic [79:0] sum  [3];
  logic [63:0] mx   [3];
  logic [15:0] mis  [3];
  logic [15:0] smp  [3];

  int hs_cnt [3];
  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] qa[$];
  logic [63:0] qe[$];
  bit          vpat[$];

  logic [79:0] exp_sum;
  logic [63:0] exp_max;
  int          exp_mis;

  always #5 clk = ~clk;

  approx_err_accum #(.N_SAMPLES(4), .CNT_W(CNT_W)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy[0]),
    .p_approx(p_approx), .p_exact(p_exact), .busy(busy[0]), .done(done[0]),
    .err_sum(sum[0]), .err_max(mx[0]), .mis_cnt(mis[0]), .smp_cnt(smp[0]));

  approx_err_accum #(.N_SAMPLES(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy[1]),
    .p_approx(p_approx), .p_exact(p_exact), .busy(busy[1]), .done(done[1]),
    .err_sum(sum[1]), .err_max(mx[1]), .mis_cnt(mis[1]), .smp_cnt(smp[1]));

  approx_err_accum #(.N_SAMPLES(1024), .CNT_W(CNT_W)) dut_big (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy[2]),
    .p_approx(p_approx), .p_exact(p_exact), .busy(busy[2]), .done(done[2]),
    .err_sum(sum[2]), .err_max(mx[2]), .mis_cnt(mis[2]), .smp_cnt(smp[2]));

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (in_valid && rdy[i]) hs_cnt[i] <= hs_cnt[i] + 1;
  end

  // Reference: true distance between two signed 64-bit values.
  function automatic logic [63:0] abs_err(input logic [63:0] a, input logic [63:0] e);
    longint sa = longint'(a);
    longint se = longint'(e);
    if (sa >= se) return a - e;
    return e - a;
  endfunction

  task automatic model_clear();
    exp_sum = '0;
    exp_max = '0;
    exp_mis = 0;
    qa.delete();
    qe.delete();
    vpat.delete();
  endtask

  task automatic push_pair(input logic [63:0] a, input logic [63:0] e);
    logic [63:0] d = abs_err(a, e);
    exp_sum += {16'd0, d};
    if (d > exp_max) exp_max = d;
    if (a != e) exp_mis++;
    qa.push_back(a);
    qe.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer every pair in qa/qe to one instance, honouring vpat gaps; returns
  // just after the edge that accepted the last pair.
  task automatic stream(input int inst, output bit ok);
    int idx = 0;
    int cyc = 0;
    ok = 1'b1;
    while (idx < qa.size()) begin
      @(negedge clk);
      in_valid = (cyc < vpat.size()) ? vpat[cyc] : 1'b1;
      p_approx = qa[idx];
      p_exact  = qe[idx];
      cyc++;
      if (in_valid && rdy[inst]) idx++;
      @(posedge clk);
      if (cyc > 4000) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_done(input int inst, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done[inst]) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({rdy[0], busy[0], done[0], sum[0], mx[0], mis[0], smp[0]} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got rdy=%b busy=%b done=%b sum=%h max=%h mis=%0d smp=%0d expected all 0",
               rdy[0], busy[0], done[0], sum[0], mx[0], mis[0], smp[0]);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    int hs0 = hs_cnt[0];
    do_reset();
    model_clear();
    push_pair(64'd10, 64'd10);
    push_pair(64'd12, 64'd10);
    push_pair(-64'sd5, 64'd3);
    push_pair(64'd0, -64'sd7);
    do_start();
    stream(0, ok);
    wait_done(0, lat);
    n_checks++;
    if (!ok || lat !== 4) begin
      n_fail++;
      $display("[TB] FAIL basic_done_latency: got %0d expected 4 (stream ok=%0b)", lat, ok);
    end
    n_checks++;
    if (sum[0] !== exp_sum || exp_sum !== 80'd17) begin
      n_fail++;
      $display("[TB] FAIL basic_err_sum: got %0d expected 17", sum[0]);
    end
    n_checks++;
    if (mx[0] !== exp_max || mis[0] !== 16'(exp_mis)) begin
      n_fail++;
      $display("[TB] FAIL basic_max_mis: got max=%0d mis=%0d expected max=%0d mis=%0d",
               mx[0], mis[0], exp_max, exp_mis);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (smp[0] !== 16'd4 || hs_cnt[0] - hs0 !== 4 || done[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL basic_handshakes: got smp=%0d hs=%0d done=%b expected 4 4 1",
               smp[0], hs_cnt[0] - hs0, done[0]);
    end
  endtask

  task automatic test_extreme();
    bit ok;
    int lat;
    do_reset();
    model_clear();
    push_pair(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    do_start();
    stream(1, ok);
    wait_done(1, lat);
    n_checks++;
    if (!ok || lat < 0 || mx[1] !== 64'hFFFF_FFFF_FFFF_FFFF || mx[1] !== exp_max) begin
      n_fail++;
      $display("[TB] FAIL extreme_err_max: got %h expected ffffffffffffffff", mx[1]);
    end
    n_checks++;
    if (sum[1] !== 80'h0_FFFF_FFFF_FFFF_FFFF || mis[1] !== 16'd1) begin
      n_fail++;
      $display("[TB] FAIL extreme_err_sum: got sum=%h mis=%0d expected sum=0000ffffffffffffffff mis=1",
               sum[1], mis[1]);
    end
  endtask

  task automatic test_gaps();
    bit ok;
    int lat;
    int hs0;
    logic [63:0] e;
    do_reset();
    model_clear();
    for (int i = 0; i < 4; i++) begin
      e = 64'($urandom) - 64'd100000;
      push_pair(e + 64'd1, e);
    end
    vpat = '{1, 0, 0, 1, 1, 0, 1};
    do_start();
    hs0 = hs_cnt[0];
    stream(0, ok);
    @(negedge clk);
    n_checks++;
    if (!ok || in_valid !== 1'b1 || rdy[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL gaps_ready_drop: got in_ready=%b expected 0 (in_valid=%b)", rdy[0], in_valid);
    end
    wait_done(0, lat);
    n_checks++;
    if (lat < 0 || sum[0] !== 80'd4 || mis[0] !== 16'd4 || hs_cnt[0] - hs0 !== 4) begin
      n_fail++;
      $display("[TB] FAIL gaps_results: got sum=%0d mis=%0d hs=%0d expected 4 4 4",
               sum[0], mis[0], hs_cnt[0] - hs0);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int lat;
    do_reset();
    model_clear();
    for (int i = 0; i < 2; i++) push_pair({$urandom, $urandom}, {$urandom, $urandom});
    do_start();
    stream(0, ok);
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (!ok || smp[0] !== 16'd2 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL start_in_run: got smp=%0d busy=%b expected 2 1", smp[0], busy[0]);
    end
    qa.delete();
    qe.delete();
    for (int i = 0; i < 2; i++) push_pair({$urandom, $urandom}, {$urandom, $urandom});
    stream(0, ok);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (!ok || busy[0] !== 1'b1 || done[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL start_in_drain: got busy=%b done=%b expected 1 0", busy[0], done[0]);
    end
    wait_done(0, lat);
    n_checks++;
    if (lat < 0 || sum[0] !== exp_sum || mx[0] !== exp_max || mis[0] !== 16'(exp_mis) || smp[0] !== 16'd4) begin
      n_fail++;
      $display("[TB] FAIL start_ignored_results: got sum=%h max=%h mis=%0d smp=%0d expected sum=%h max=%h mis=%0d smp=4",
               sum[0], mx[0], mis[0], smp[0], exp_sum, exp_max, exp_mis);
    end
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({sum[0], mx[0], mis[0], smp[0]} !== '0 || done[0] !== 1'b0 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL start_in_done: got sum=%h max=%h mis=%0d smp=%0d done=%b busy=%b expected 0 0 0 0 0 1",
               sum[0], mx[0], mis[0], smp[0], done[0], busy[0]);
    end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int lat;
    do_reset();
    model_clear();
    for (int i = 0; i < 2; i++) push_pair({$urandom, $urandom}, 64'd0);
    do_start();
    stream(0, ok);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (!ok || {rdy[0], busy[0], done[0], sum[0], mx[0], mis[0], smp[0]} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_midrun_clear: got busy=%b done=%b sum=%h max=%h mis=%0d smp=%0d expected all 0",
               busy[0], done[0], sum[0], mx[0], mis[0], smp[0]);
    end
    model_clear();
    for (int i = 0; i < 4; i++) push_pair(64'(i * 3), 64'(i));
    do_start();
    stream(0, ok);
    wait_done(0, lat);
    n_checks++;
    if (!ok || lat < 0 || sum[0] !== exp_sum || mx[0] !== exp_max || mis[0] !== 16'(exp_mis)) begin
      n_fail++;
      $display("[TB] FAIL reset_midrun_rerun: got sum=%0d max=%0d mis=%0d expected sum=%0d max=%0d mis=%0d",
               sum[0], mx[0], mis[0], exp_sum, exp_max, exp_mis);
    end
  endtask

  task automatic test_random();
    bit ok;
    int lat;
    longint ex;
    logic [63:0] mask;
    do_reset();
    model_clear();
    for (int i = 0; i < 1024; i++) begin
      ex   = longint'(int'($urandom)) * longint'(int'($urandom));
      mask = (64'd1 << $urandom_range(0, 20)) - 64'd1;
      if ($urandom_range(0, 3) == 0) mask = '0;
      push_pair(64'(ex) ^ ({$urandom, $urandom} & mask), 64'(ex));
    end
    for (int i = 0; i < 1400; i++) vpat.push_back($urandom_range(0, 3) != 0);
    do_start();
    stream(2, ok);
    wait_done(2, lat);
    n_checks++;
    if (!ok || lat < 0 || sum[2] !== exp_sum) begin
      n_fail++;
      $display("[TB] FAIL random_err_sum: got %h expected %h", sum[2], exp_sum);
    end
    n_checks++;
    if (mx[2] !== exp_max) begin
      n_fail++;
      $display("[TB] FAIL random_err_max: got %h expected %h", mx[2], exp_max);
    end
    n_checks++;
    if (mis[2] !== 16'(exp_mis) || smp[2] !== 16'd1024) begin
      n_fail++;
      $display("[TB] FAIL random_counts: got mis=%0d smp=%0d expected mis=%0d smp=1024",
               mis[2], smp[2], exp_mis);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    p_approx = '0; p_exact = '0;
    test_reset();
    test_basic();
    test_extreme();
    test_gaps();
    test_start_ignored();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
